phase_to_sine_lut: RTL

//   Phase-to-amplitude converter. Reads the 32-bit phase word from the

---
 rtl/phase_to_sine_lut.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/phase_to_sine_lut.sv
// Phase-to-amplitude converter for the sine generator.
// A quarter-wave ROM plus quadrant folding produces a signed sine sample
// from the top bits of the phase accumulator word. The pipeline has three
// stages, accepts one sample per clock and carries a valid flag alongside.
`timescale 1ns/1ps

module phase_to_sine_lut #(
   parameter int unsigned PHASE_W = 32,
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned AMP_W   = 16
) (
   input  logic                    CLK,
   input  logic                    RSTN,
   input  logic                    SCLR,
   input  logic [PHASE_W-1:0]      phase_in,
   input  logic                    phase_valid,
   output logic signed [AMP_W-1:0] sine_out,
   output logic                    sine_valid,
   output logic [1:0]              quadrant,
   output logic                    zero_cross
);

   localparam int unsigned Depth = 1 << ADDR_W;
   localparam real         Pi    = 3.14159265358979323846;

   // Taylor series sine. The argument is never larger than pi/2, so 12 terms
   // are far below one output LSB of error.
   function automatic real sin_taylor(input real x);
      real term;
      real sum;
      term = x;
      sum  = x;
      for (int k = 1; k < 12; k++) begin
         term = -term * x * x / real'((2 * k) * (2 * k + 1));
         sum  = sum + term;
      end
      return sum;
   endfunction

   // One quarter-wave entry, sampled at the bin centre (the half-LSB offset
   // means the table never holds an exact zero).
   function automatic logic [AMP_W-2:0] lut_entry(input int unsigned idx);
      real ang;
      int  v;
      ang = (Pi / 2.0) * (real'(idx) + 0.5) / real'(Depth);
      v   = $rtoi(real'((1 << (AMP_W - 1)) - 1) * sin_taylor(ang) + 0.5);
      return v[AMP_W-2:0];
   endfunction

   logic [AMP_W-2:0] lut [Depth];

   for (genvar i = 0; i < Depth; i++) begin : g_lut
      assign lut[i] = lut_entry(i);
   end

   // Field split; the phase bits below the ROM address are truncated.
   logic [1:0]        q_in;
   logic [ADDR_W-1:0] a_in;
   logic              unused_low_bits;

   assign q_in            = phase_in[PHASE_W-1 -: 2];
   assign a_in            = phase_in[PHASE_W-3 -: ADDR_W];
   assign unused_low_bits = ^phase_in[PHASE_W-3-ADDR_W:0];

   logic [1:0]              q1, q2;
   logic [ADDR_W-1:0]       addr1;
   logic                    v1, v2;
   logic [AMP_W-2:0]        rom_q;
   logic signed [AMP_W-1:0] mag;
   logic                    prev_sign;
   logic                    have_prev;

   // Stage 1: register quadrant, folded address (odd quadrants run backwards) and valid.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         q1    <= '0;
         addr1 <= '0;
         v1    <= 1'b0;
      end else if (SCLR) begin
         q1    <= '0;
         addr1 <= '0;
         v1    <= 1'b0;
      end else begin
         q1    <= q_in;
         addr1 <= q_in[0] ? ~a_in : a_in;
         v1    <= phase_valid;
      end
   end

   // Stage 2 data: synchronous ROM read, left without reset so it maps to block RAM.
   // Its contents only reach the output when qualified by v2.
   always_ff @(posedge CLK) begin
      rom_q <= lut[addr1];
   end

   // Stage 2 control: delay quadrant and valid alongside the ROM read.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         q2 <= '0;
         v2 <= 1'b0;
      end else if (SCLR) begin
         q2 <= '0;
         v2 <= 1'b0;
      end else begin
         q2 <= q1;
         v2 <= v1;
      end
   end

   // Magnitude is at most 2^(AMP_W-1)-1, so negation cannot overflow.
   assign mag = signed'({1'b0, rom_q});

   // Stage 3: apply sign, hold outputs through bubbles, flag sign changes.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         sine_out   <= '0;
         sine_valid <= 1'b0;
         quadrant   <= '0;
         zero_cross <= 1'b0;
         prev_sign  <= 1'b0;
         have_prev  <= 1'b0;
      end else if (SCLR) begin
         sine_out   <= '0;
         sine_valid <= 1'b0;
         quadrant   <= '0;
         zero_cross <= 1'b0;
         prev_sign  <= 1'b0;
         have_prev  <= 1'b0;
      end else begin
         sine_valid <= v2;
         zero_cross <= 1'b0;
         if (v2) begin
            sine_out   <= q2[1] ? -mag : mag;
            quadrant   <= q2;
            zero_cross <= have_prev && (q2[1] != prev_sign);
            prev_sign  <= q2[1];
            have_prev  <= 1'b1;
         end
      end
   end

endmodule
